// File: rtl/assoc_cache.sv
// assoc_cache: N-way set-associative cache with 4-word lines, round-robin
// replacement and write-allocate / write-through stores. Read hits complete
// combinationally. Misses fill a victim way from memory and then replay the
// request as a hit. Write hits send the merged line to memory before updating
// the local copy. With BYPASS=1 the block is a pure pass-through.
module assoc_cache #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_SETS  = 4,
    parameter int NUM_WAYS  = 2,
    parameter int BYPASS    = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   readC,
    input  logic                   writeC,
    input  logic [WORD_SIZE-1:0]   address,
    inout  wire  [WORD_SIZE-1:0]   data,
    output logic                   readyC,
    output logic                   readM,
    output logic                   writeM,
    inout  wire  [4*WORD_SIZE-1:0] dataM,
    input  logic                   input_readyM,
    input  logic                   doneM,
    output logic [WORD_SIZE-1:0]   num_cache_access,
    output logic [WORD_SIZE-1:0]   num_cache_miss
);

    localparam int SET_BITS = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 0;
    localparam int IDX_W    = (SET_BITS > 0) ? SET_BITS : 1;
    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int TAG_W    = WORD_SIZE - 2 - SET_BITS;
    localparam int LINE_W   = 4 * WORD_SIZE;
    localparam bit BYP      = (BYPASS != 0);
    localparam logic [WORD_SIZE-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

    genvar gi;

    // Address fields
    logic [1:0]       offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;

    assign offset = address[1:0];
    assign tag    = address[WORD_SIZE-1:2+SET_BITS];

    generate
        if (SET_BITS == 0) begin : g_idx_none
            assign index = '0;
        end else begin : g_idx
            assign index = address[2+SET_BITS-1:2];
        end
    endgenerate

    // Storage: valid bits and pointers are reset; tags and lines need not be
    logic              valid_reg [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]  ptr_reg   [NUM_SETS];
    logic [TAG_W-1:0]  tag_reg   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0] line_reg  [NUM_SETS][NUM_WAYS];

    // Control state and captured transaction context
    state_t            state_reg, state_next;
    logic [WORD_SIZE-1:0] access_reg, miss_reg;
    logic [IDX_W-1:0]  fill_idx_reg, wr_idx_reg;
    logic [WAY_W-1:0]  fill_way_reg, wr_way_reg;
    logic [TAG_W-1:0]  fill_tag_reg;
    logic [LINE_W-1:0] wr_line_reg;

    // Lookup results
    logic [NUM_WAYS-1:0] hit_vec;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    victim_way;
    logic                all_valid;
    logic [WAY_W-1:0]    ptr_inc;
    logic [LINE_W-1:0]   hit_line;
    logic [LINE_W-1:0]   merged_line;
    logic [WORD_SIZE-1:0] hit_words [4];
    logic [WORD_SIZE-1:0] mem_words [4];
    logic                start_fetch, start_write;
    logic [WORD_SIZE-1:0] data_out;
    logic [LINE_W-1:0]   dataM_out;

    // Per-way tag compare in the addressed set
    generate
        for (gi = 0; gi < NUM_WAYS; gi++) begin : g_hit
            assign hit_vec[gi] = valid_reg[index][gi] && (tag_reg[index][gi] == tag);
        end
    endgenerate

    // Encode the (at most one) matching way
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (hit_vec[w]) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Victim: lowest invalid way, else the set's round-robin pointer
    always_comb begin
        victim_way = ptr_reg[index];
        all_valid  = 1'b1;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_reg[index][w]) begin
                victim_way = WAY_W'(w);
                all_valid  = 1'b0;
            end
        end
    end

    assign ptr_inc  = (NUM_WAYS > 1) ? ptr_reg[index] + WAY_W'(1) : '0;
    assign hit_line = line_reg[index][hit_way];

    // Word views of the hit line and the memory bus, plus the store merge
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word
            assign hit_words[gi] = hit_line[gi*WORD_SIZE +: WORD_SIZE];
            assign mem_words[gi] = dataM[gi*WORD_SIZE +: WORD_SIZE];
            assign merged_line[gi*WORD_SIZE +: WORD_SIZE] =
                (offset == 2'(gi)) ? data : hit_line[gi*WORD_SIZE +: WORD_SIZE];
        end
    endgenerate

    // Next-state logic; the pass-through variant never leaves IDLE
    always_comb begin
        state_next  = state_reg;
        start_fetch = 1'b0;
        start_write = 1'b0;
        if (!BYP) begin
            case (state_reg)
                IDLE: begin
                    if ((readC || writeC) && !hit) begin
                        start_fetch = 1'b1;
                        state_next  = FETCH;
                    end else if (writeC && hit) begin
                        start_write = 1'b1;
                        state_next  = WRITE;
                    end
                end
                FETCH:   if (input_readyM) state_next = IDLE;
                WRITE:   if (doneM) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Handshake outputs and bus data selection
    always_comb begin
        if (BYP) begin
            readM     = readC;
            writeM    = writeC;
            readyC    = (readC && input_readyM) || (writeC && doneM);
            data_out  = mem_words[offset];
            dataM_out = {4{data}};
        end else begin
            readM     = (state_reg == FETCH);
            writeM    = (state_reg == WRITE);
            readyC    = ((state_reg == IDLE) && readC && hit) ||
                        ((state_reg == WRITE) && doneM && writeC);
            data_out  = hit_words[offset];
            dataM_out = wr_line_reg;
        end
    end

    assign data  = (readC && readyC) ? data_out : {WORD_SIZE{1'bz}};
    assign dataM = writeM ? dataM_out : {LINE_W{1'bz}};

    assign num_cache_access = access_reg;
    assign num_cache_miss   = miss_reg;

    // State, counters, valid bits, pointers and transaction context
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            access_reg   <= '0;
            miss_reg     <= '0;
            fill_idx_reg <= '0;
            fill_way_reg <= '0;
            fill_tag_reg <= '0;
            wr_idx_reg   <= '0;
            wr_way_reg   <= '0;
            wr_line_reg  <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                ptr_reg[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_reg[s][w] <= 1'b0;
                end
            end
        end else begin
            state_reg <= state_next;
            if (readyC && !BYP) begin
                access_reg <= access_reg + CNT_ONE;
            end
            if (start_fetch) begin
                miss_reg     <= miss_reg + CNT_ONE;
                fill_idx_reg <= index;
                fill_tag_reg <= tag;
                fill_way_reg <= victim_way;
                if (all_valid) begin
                    ptr_reg[index] <= ptr_inc;
                end
            end
            if (start_write) begin
                wr_idx_reg  <= index;
                wr_way_reg  <= hit_way;
                wr_line_reg <= merged_line;
            end
            if ((state_reg == FETCH) && input_readyM) begin
                valid_reg[fill_idx_reg][fill_way_reg] <= 1'b1;
            end
        end
    end

    // Tag and line arrays; a reset forces IDLE first, so no partial fill lands
    always_ff @(posedge clk) begin
        if ((state_reg == FETCH) && input_readyM) begin
            line_reg[fill_idx_reg][fill_way_reg] <= dataM;
            tag_reg[fill_idx_reg][fill_way_reg]  <= fill_tag_reg;
        end
        if ((state_reg == WRITE) && doneM) begin
            line_reg[wr_idx_reg][wr_way_reg] <= wr_line_reg;
        end
    end

endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: table-driven directed test of assoc_cache (4 sets, 2 ways)
// with a one-cycle-latency memory responder, plus hand sequences for reset
// during a fill and for the pass-through variant.
module tb_assoc_cache;

    localparam int LAT = 1;
    localparam logic [63:0] LINE_A = 64'h4444_3333_2222_1111;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        readC, writeC;
    logic [15:0] address;
    logic [15:0] cpu_wdata;
    wire  [15:0] data;
    logic        readyC, readM, writeM;
    wire  [63:0] dataM;
    logic        mem_drive;
    logic [63:0] mem_line;
    logic        input_readyM, doneM;
    logic [15:0] acc, miss;

    // pass-through instance signals
    logic        readC_b, writeC_b;
    logic [15:0] address_b, cpu_b_wdata;
    wire  [15:0] data_b;
    logic        readyC_b, readM_b, writeM_b;
    wire  [63:0] dataM_b;
    logic        mem_b_drive;
    logic        input_readyM_b, doneM_b;
    logic [15:0] acc_b, miss_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign data    = writeC ? cpu_wdata : 16'hzzzz;
    assign dataM   = mem_drive ? mem_line : {64{1'bz}};
    assign data_b  = writeC_b ? cpu_b_wdata : 16'hzzzz;
    assign dataM_b = mem_b_drive ? LINE_A : {64{1'bz}};

    assoc_cache #(.WORD_SIZE(16), .NUM_SETS(4), .NUM_WAYS(2), .BYPASS(0)) u_dut (
        .clk(clk), .reset_n(reset_n), .readC(readC), .writeC(writeC),
        .address(address), .data(data), .readyC(readyC), .readM(readM),
        .writeM(writeM), .dataM(dataM), .input_readyM(input_readyM),
        .doneM(doneM), .num_cache_access(acc), .num_cache_miss(miss)
    );

    assoc_cache #(.WORD_SIZE(16), .NUM_SETS(4), .NUM_WAYS(2), .BYPASS(1)) u_byp (
        .clk(clk), .reset_n(reset_n), .readC(readC_b), .writeC(writeC_b),
        .address(address_b), .data(data_b), .readyC(readyC_b), .readM(readM_b),
        .writeM(writeM_b), .dataM(dataM_b), .input_readyM(input_readyM_b),
        .doneM(doneM_b), .num_cache_access(acc_b), .num_cache_miss(miss_b)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [63:0] line;    // memory contents served on a fill
        logic        is_miss;
        int          cyc;     // cycles from request to readyC, inclusive
        logic [15:0] rdata;
        logic [63:0] wline;
        logic [15:0] acc;
        logic [15:0] mis;
    } vec_t;

    vec_t vt [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs the already-presented request to completion, acting as memory.
    // Entered and left at a falling edge.
    task automatic service(output int cyc, output int rm, output int wm,
                           output logic [15:0] rd, output logic [63:0] wl,
                           output logic ok);
        int mc;
        mc = 0; ok = 1'b0; cyc = 0; rm = 0; wm = 0; rd = '0; wl = '0;
        for (int c = 0; c < 40 && !ok; c++) begin
            input_readyM = 1'b0; doneM = 1'b0; mem_drive = 1'b0;
            if (readM) begin
                rm++;
                if (mc == LAT) begin
                    mem_drive = 1'b1;
                    input_readyM = 1'b1;
                end
                mc++;
            end else if (writeM) begin
                wm++;
                if (mc == LAT) doneM = 1'b1;
                mc++;
            end else begin
                mc = 0;
            end
            #1;
            cyc++;
            if (writeM) wl = dataM;
            if (readyC) begin
                ok = 1'b1;
                rd = data;
            end
            @(negedge clk);
        end
        input_readyM = 1'b0; doneM = 1'b0; mem_drive = 1'b0;
    endtask

    task automatic apply_vec(input int n);
        vec_t v;
        int cyc, rm, wm;
        logic [15:0] rd;
        logic [63:0] wl;
        logic ok;
        v = vt[n];
        address   = v.addr;
        cpu_wdata = v.wdata;
        mem_line  = v.line;
        readC     = !v.wr;
        writeC    = v.wr;
        service(cyc, rm, wm, rd, wl, ok);
        readC  = 1'b0;
        writeC = 1'b0;
        #1;
        $display("vec %0d: %s addr=%h cycles=%0d rd=%h wline=%h acc=%0d miss=%0d",
                 n, v.wr ? "WR" : "RD", v.addr, cyc, rd, wl, acc, miss);
        check($sformatf("vec%0d_done", n), 64'(ok), 64'(1));
        check($sformatf("vec%0d_cycles", n), 64'(cyc), 64'(v.cyc));
        check($sformatf("vec%0d_readM_cycles", n), 64'(rm), 64'(v.is_miss ? LAT + 1 : 0));
        check($sformatf("vec%0d_writeM_cycles", n), 64'(wm), 64'(v.wr ? LAT + 1 : 0));
        if (v.wr) check($sformatf("vec%0d_wline", n), wl, v.wline);
        else      check($sformatf("vec%0d_rdata", n), 64'(rd), 64'(v.rdata));
        check($sformatf("vec%0d_access", n), 64'(acc), 64'(v.acc));
        check($sformatf("vec%0d_miss", n), 64'(miss), 64'(v.mis));
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        // wr addr wdata line miss cyc rdata wline acc miss
        vt[0]  = '{1'b0, 16'h0040, 16'h0, LINE_A, 1'b1, 4, 16'h1111, 64'h0, 16'd1, 16'd1};
        vt[1]  = '{1'b0, 16'h0042, 16'h0, 64'h0,  1'b0, 1, 16'h3333, 64'h0, 16'd2, 16'd1};
        vt[2]  = '{1'b1, 16'h0041, 16'h5555, 64'h0, 1'b0, 3, 16'h0, 64'h4444_3333_5555_1111, 16'd3, 16'd1};
        vt[3]  = '{1'b0, 16'h0041, 16'h0, 64'h0,  1'b0, 1, 16'h5555, 64'h0, 16'd4, 16'd1};
        vt[4]  = '{1'b1, 16'h0080, 16'h0ABC, 64'hB004_B003_B002_B001, 1'b1, 6, 16'h0,
                   64'hB004_B003_B002_0ABC, 16'd5, 16'd2};
        vt[5]  = '{1'b0, 16'h0080, 16'h0, 64'h0,  1'b0, 1, 16'h0ABC, 64'h0, 16'd6, 16'd2};
        // after reset mid-fill
        vt[6]  = '{1'b0, 16'h00C0, 16'h0, 64'hD003_D002_D001_D000, 1'b1, 4, 16'hD000, 64'h0, 16'd1, 16'd1};
        vt[7]  = '{1'b0, 16'h0040, 16'h0, LINE_A, 1'b1, 4, 16'h1111, 64'h0, 16'd2, 16'd2};
        // replacement in set 0 after a fresh reset
        vt[8]  = '{1'b0, 16'h0000, 16'h0, 64'hA003_A002_A001_A000, 1'b1, 4, 16'hA000, 64'h0, 16'd1, 16'd1};
        vt[9]  = '{1'b0, 16'h0010, 16'h0, 64'hA013_A012_A011_A010, 1'b1, 4, 16'hA010, 64'h0, 16'd2, 16'd2};
        vt[10] = '{1'b0, 16'h0020, 16'h0, 64'hA023_A022_A021_A020, 1'b1, 4, 16'hA020, 64'h0, 16'd3, 16'd3};
        vt[11] = '{1'b0, 16'h0010, 16'h0, 64'h0,  1'b0, 1, 16'hA010, 64'h0, 16'd4, 16'd3};
        vt[12] = '{1'b0, 16'h0000, 16'h0, 64'hA003_A002_A001_A000, 1'b1, 4, 16'hA000, 64'h0, 16'd5, 16'd4};
        vt[13] = '{1'b0, 16'h0020, 16'h0, 64'h0,  1'b0, 1, 16'hA020, 64'h0, 16'd6, 16'd4};
        vt[14] = '{1'b0, 16'h0010, 16'h0, 64'hA013_A012_A011_A010, 1'b1, 4, 16'hA010, 64'h0, 16'd7, 16'd5};

        reset_n = 1'b0;
        readC = 0; writeC = 0; address = '0; cpu_wdata = '0;
        mem_drive = 0; mem_line = '0; input_readyM = 0; doneM = 0;
        readC_b = 0; writeC_b = 0; address_b = '0; cpu_b_wdata = '0;
        mem_b_drive = 0; input_readyM_b = 0; doneM_b = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        $display("reset: readyC=%b readM=%b writeM=%b acc=%0d miss=%0d", readyC, readM, writeM, acc, miss);
        check("reset_readyC", 64'(readyC), 64'(0));
        check("reset_readM", 64'(readM), 64'(0));
        check("reset_writeM", 64'(writeM), 64'(0));
        check("reset_access", 64'(acc), 64'(0));
        check("reset_miss", 64'(miss), 64'(0));
        @(negedge clk);

        for (int i = 0; i <= 5; i++) apply_vec(i);

        // Reset asserted while a fill is outstanding
        readC = 1'b1; address = 16'h00C0;
        #1 check("abort_req_readyC", 64'(readyC), 64'(0));
        @(negedge clk);
        #1 check("abort_fetch_readM", 64'(readM), 64'(1));
        #1 reset_n = 1'b0;
        #1;
        $display("abort: readM=%b acc=%0d miss=%0d", readM, acc, miss);
        check("abort_readM_drop", 64'(readM), 64'(0));
        check("abort_access", 64'(acc), 64'(0));
        check("abort_miss", 64'(miss), 64'(0));
        readC = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 6; i <= 7; i++) apply_vec(i);
        do_reset();
        @(negedge clk);
        for (int i = 8; i <= 14; i++) apply_vec(i);

        // Pass-through variant
        readC_b = 1'b1; address_b = 16'h0042;
        #1;
        check("byp_rd_readM", 64'(readM_b), 64'(1));
        check("byp_rd_wait", 64'(readyC_b), 64'(0));
        @(negedge clk);
        mem_b_drive = 1'b1; input_readyM_b = 1'b1;
        #1;
        $display("bypass read: readyC=%b data=%h", readyC_b, data_b);
        check("byp_rd_ready", 64'(readyC_b), 64'(1));
        check("byp_rd_data", 64'(data_b), 64'(16'h3333));
        @(negedge clk);
        readC_b = 1'b0; mem_b_drive = 1'b0; input_readyM_b = 1'b0;
        #1;
        check("byp_rd_access", 64'(acc_b), 64'(0));
        check("byp_rd_readM_low", 64'(readM_b), 64'(0));
        writeC_b = 1'b1; address_b = 16'h0041; cpu_b_wdata = 16'h7777;
        #1;
        check("byp_wr_writeM", 64'(writeM_b), 64'(1));
        check("byp_wr_dataM", dataM_b, 64'h7777_7777_7777_7777);
        check("byp_wr_wait", 64'(readyC_b), 64'(0));
        @(negedge clk);
        doneM_b = 1'b1;
        #1;
        $display("bypass write: readyC=%b dataM=%h", readyC_b, dataM_b);
        check("byp_wr_ready", 64'(readyC_b), 64'(1));
        @(negedge clk);
        writeC_b = 1'b0; doneM_b = 1'b0;
        #1;
        check("byp_access", 64'(acc_b), 64'(0));
        check("byp_miss", 64'(miss_b), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/assoc_cache.md
# assoc_cache

Parametrised N-way set-associative cache between a pipeline memory port (instruction or data side) and a 4-word-line memory. Generalises the direct-mapped cache in the CPU top to configurable set count and associativity, adds round-robin replacement and write-allocate/write-through stores, and keeps the existing CPU-side and memory-side handshake signals and access/miss counters. It is instantiated once per memory port.

## Interface
- `WORD_SIZE`, 16, data and address width.
- `NUM_SETS`, 4, number of sets; a power of two, at least 1.
- `NUM_WAYS`, 2, associativity; a power of two, 1 to 8.
- `BYPASS`, 0, when 1 the cache is a pass-through and stores no lines.

Ports:
- `clk` input 1: clock, rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `readC` input 1: CPU read request, held until `readyC`.
- `writeC` input 1: CPU write request, held until `readyC`. `readC` and `writeC` are never both high.
- `address` input WORD_SIZE: word address. Memory also receives this address directly; this block does not drive a memory address.
- `data` inout WORD_SIZE: CPU data. Driven by the cache while `readC && readyC`, otherwise high-Z. Driven by the CPU during writes.
- `readyC` output 1: request complete (combinational).
- `readM` output 1: memory line-read request.
- `writeM` output 1: memory line-write request.
- `dataM` inout 4*WORD_SIZE: memory line. Word k occupies bits [16k+15:16k]. Driven by the cache while `writeM`, otherwise high-Z.
- `input_readyM` input 1: memory read data valid.
- `doneM` input 1: memory write accepted.
- `num_cache_access` output WORD_SIZE: count of completed requests.
- `num_cache_miss` output WORD_SIZE: count of misses.

## Operation
- Address split: `offset` = address[1:0]; `index` = next log2(NUM_SETS) bits (none if NUM_SETS=1); `tag` = the remaining bits.
- Per way and set storage: valid bit, tag, and a 4-word line. Per set: a round-robin pointer of log2(NUM_WAYS) bits.
- Hit: some valid way in set `index` has a matching tag. At most one way can match.
- FSM states are IDLE, FETCH and WRITE.
- IDLE, read hit:
  - `readyC`=1 in the same cycle.
  - `data` = hit line word `offset`.
- IDLE, write hit:
  - Register the merged line: hit line with word `offset` replaced by `data`.
  - Register the hit way.
  - Go to WRITE.
- IDLE, any miss (read or write): increment `num_cache_miss` and go to FETCH.
  - Victim = the lowest-index invalid way. If every way is valid, the victim is the way the set's pointer names, and the pointer then increments mod NUM_WAYS.
  - The pointer advances only when a valid line is evicted.
- FETCH:
  - `readM`=1.
  - On the edge where `input_readyM`=1: write `dataM` into the victim way, set its valid bit and tag, and go to IDLE.
  - The request is then re-evaluated in IDLE and hits.
- WRITE:
  - `writeM`=1 and `dataM` = the merged line.
  - On the edge where `doneM`=1: write the merged line into the recorded way and go to IDLE.
  - `readyC`=1 combinationally in the cycle `doneM`=1.
- Counters:
  - `num_cache_access` increments on every edge where `readyC`=1.
  - A miss counts once, even though the request then completes as a hit.
  - Both counters wrap modulo 2^WORD_SIZE.
- Request dropped mid-FETCH: the fill still completes, no `readyC` is issued, and the FSM returns to IDLE.
- Request dropped mid-WRITE: the write still completes.
- BYPASS=1:
  - `readM`=`readC` and `writeM`=`writeC`.
  - `readyC` = `input_readyM` for reads and `doneM` for writes.
  - Read `data` = `dataM` word `offset`.
  - Write `dataM` = `data` replicated into all 4 words.
  - No storage, FSM held in IDLE, counters held at 0.

## Timing
- Reset values:
  - Outputs: `readyC`=0, `readM`=0, `writeM`=0, counters 0, `data` and `dataM` high-Z.
  - Internal: all valid bits 0, pointers 0, state IDLE.
- A reset in FETCH or WRITE aborts the transaction: `readM`/`writeM` drop immediately, and no partial line is written.
- Read-hit latency is 0 cycles: `readyC` is combinational in the request cycle.
- Read-miss latency = memory latency + 1 cycle: the FETCH cycles, then 1 IDLE hit cycle.
- Write-hit latency = 1 cycle to enter WRITE + cycles until `doneM`.
- Write miss = FETCH, then 1 IDLE cycle, then WRITE.
- `readM`/`writeM` are registered-state decodes. They fall in the cycle after `input_readyM`/`doneM` is sampled.
- A back-to-back request may start in the cycle after `readyC`.

## Test plan
- Reset, then read 0x0040 with memory returning line {0x1111,0x2222,0x3333,0x4444} -> `readM` asserted until `input_readyM`, then `readyC` with `data`=0x1111. Counters access=1, miss=1.
- Read 0x0042 next -> `readyC` in the same cycle, `data`=0x3333, `readM` stays 0. Counters access=2, miss=1.
- NUM_SETS=4, NUM_WAYS=2: read 0x0000, 0x0010, 0x0020 (all index 0) -> third read evicts way 0 (pointer 0→1). Re-reading 0x0000 misses, evicts way 1, and leaves 0x0020 resident.
- Write 0x5555 to 0x0041 after the first test -> `writeM` with `dataM`={0x1111,0x5555,0x3333,0x4444}. `readyC` in the `doneM` cycle. A following read of 0x0041 hits and returns 0x5555.
- Write miss to 0x0080 -> FETCH, then WRITE. Counters access+1, miss+1.
- Assert `reset_n`=0 mid-FETCH -> `readM` falls immediately, counters go to 0, and a later read of the same address misses. Separately, BYPASS=1 read -> `readyC` follows `input_readyM` and counters stay 0.
